// File: rtl/pipeline_3stage_pkg.sv
// Shared width, stage count and stage payload types for the pipeline_3stage datapath.
package pipeline_3stage_pkg;

    localparam int DATA_W = 10;
    localparam int STAGES = 3;

    typedef struct packed {
        logic [DATA_W-1:0] x1;
        logic [DATA_W-1:0] x2;
        logic [DATA_W-1:0] d;
    } s1_t;

    typedef struct packed {
        logic [DATA_W-1:0] x3;
        logic [DATA_W-1:0] d;
    } s2_t;

endpackage

// File: rtl/pipe_reg.sv
// Parameterised-width register with synchronous active-low clear to zero.
module pipe_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) q <= '0;
        else        q <= d;
    end

endmodule

// File: rtl/pipeline_3stage.sv
// f = ((a+b) + (c-d)) * d mod 2^N, three register stages, no stall.
// Define PIPELINE_VALID_EN to add in_valid/out_valid tracking alongside the data.
module pipeline_3stage
    import pipeline_3stage_pkg::*;
#(
    parameter int N = DATA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] c,
    input  logic [N-1:0] d,
`ifdef PIPELINE_VALID_EN
    input  logic         in_valid,
    output logic         out_valid,
`endif
    output logic [N-1:0] f
);

    s1_t          s1_d, s1_q;
    s2_t          s2_d, s2_q;
    logic [N-1:0] f_d, f_q;

    always_comb begin
        s1_d    = '0;
        s1_d.x1 = a + b;
        s1_d.x2 = c - d;
        s1_d.d  = d;
        s2_d    = '0;
        s2_d.x3 = s1_q.x1 + s1_q.x2;
        s2_d.d  = s1_q.d;
        // Product evaluated at N bits: upper half is discarded by definition.
        f_d     = s2_q.x3 * s2_q.d;
    end

    pipe_reg #(.W($bits(s1_t))) u_s1 (.clk(clk), .rst_n(rst_n), .d(s1_d), .q(s1_q));
    pipe_reg #(.W($bits(s2_t))) u_s2 (.clk(clk), .rst_n(rst_n), .d(s2_d), .q(s2_q));
    pipe_reg #(.W(N))           u_s3 (.clk(clk), .rst_n(rst_n), .d(f_d),  .q(f_q));

    assign f = f_q;

`ifdef PIPELINE_VALID_EN
    logic [STAGES-1:0] vld_d, vld_q;

    always_comb begin
        vld_d = {vld_q[STAGES-2:0], in_valid};
    end

    pipe_reg #(.W(STAGES)) u_vld (.clk(clk), .rst_n(rst_n), .d(vld_d), .q(vld_q));

    assign out_valid = vld_q[STAGES-1];
`endif

endmodule

// File: tb/tb_pipeline_3stage.sv
// Directed bench for pipeline_3stage: latency, wrap/overflow, zero multiplier, mid-stream reset.
module tb_pipeline_3stage;

    localparam int N = 10;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] a, b, c, d;
    logic [N-1:0] f;
`ifdef PIPELINE_VALID_EN
    logic         in_valid;
    logic         out_valid;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int step_no  = 0;

    always #5 clk = ~clk;

    pipeline_3stage #(.N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .b        (b),
        .c        (c),
        .d        (d),
`ifdef PIPELINE_VALID_EN
        .in_valid (in_valid),
        .out_valid(out_valid),
`endif
        .f        (f)
    );

    // Drive one operand set, take one rising edge, then check f (and out_valid) 1 time unit later.
    task automatic step(input int ai, input int bi, input int ci, input int di,
                        input bit rst, input bit vin, input int exp_f, input bit exp_v);
        logic [N-1:0] ef;
        ef      = exp_f[N-1:0];
        a       = ai[N-1:0];
        b       = bi[N-1:0];
        c       = ci[N-1:0];
        d       = di[N-1:0];
        rst_n   = ~rst;
`ifdef PIPELINE_VALID_EN
        in_valid = vin;
`endif
        @(posedge clk);
        #1;
        step_no++;
        n_assert++;
        assert (f === ef) else begin
            n_fail++;
            $error("FAIL f step %0d: observed %0d expected %0d", step_no, f, ef);
        end
`ifdef PIPELINE_VALID_EN
        n_assert++;
        assert (out_valid === exp_v) else begin
            n_fail++;
            $error("FAIL out_valid step %0d: observed %0b expected %0b", step_no, out_valid, exp_v);
        end
`else
        if (exp_v && vin) begin end
`endif
    endtask

    initial begin
        a = '0; b = '0; c = '0; d = '0; rst_n = 1'b0;
`ifdef PIPELINE_VALID_EN
        in_valid = 1'b0;
`endif
        // reset state (valid held high to show reset wins)
        step(5, 5, 5, 5,         1, 1, 0,   0);
        step(5, 5, 5, 5,         1, 1, 0,   0);
        // pipeline fill: zeros until first operands reach stage 3
        step(10, 12, 6, 3,       0, 1, 0,   0);   // -> 75
        step(10, 10, 5, 3,       0, 0, 0,   0);   // -> 66
        step(20, 11, 1, 4,       0, 1, 75,  1);   // c-d wraps -> 112
        step(8, 15, 5, 0,        0, 1, 66,  0);   // zero multiplier -> 0
        step(10, 20, 5, 3,       0, 1, 112, 1);   // -> 96
        step(30, 1, 2, 4,        0, 1, 0,   1);   // -> 116
        step(500, 500, 10, 3,    0, 1, 96,  1);   // 1007*3=3021 -> 973
        step(1, 2, 3, 4,         0, 1, 116, 1);   // (3+1023)=2, *4 -> 8
        step(7, 7, 7, 7,         0, 1, 973, 1);   // 14*7 -> 98
        // reset with three results in flight
        step(9, 9, 9, 9,         1, 1, 0,   0);
        step(2, 3, 4, 1,         0, 1, 0,   0);   // -> 8
        step(100, 200, 50, 2,    0, 0, 0,   0);   // 348*2 -> 696
        step(0, 0, 0, 0,         0, 1, 8,   1);
        step(0, 0, 0, 0,         0, 1, 696, 0);
        step(0, 0, 0, 0,         0, 1, 0,   1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
